mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating read-modify-write (RMW) counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  valid memory instruction in the MEM stage.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port mem_rd  input  32  word from data memory; combinational read.
REQ-010 SHALL have port mem_a  output  32  byte address to data memory, {addr[31:2],2'b00}.
REQ-011 SHALL have port mem_we  output  1  data-memory write enable.
REQ-012 SHALL have port mem_wd  output  32  word written to data memory.
REQ-013 SHALL have port rdata  output  32  extended load result.
REQ-014 SHALL have port stall  output  1  holds the pipeline for one cycle.
REQ-015 SHALL have port misaligned  output  1  current request is misaligned or illegal.
REQ-016 SHALL have port err_sticky  output  1  latched misaligned/illegal indicator.
REQ-017 SHALL have port rmw_cnt  output  CNT_W  count of completed sub-word stores.

Function
REQ-018 SHALL use little-endian byte lanes: byte k occupies mem_rd/mem_wd bits [8k+7:8k], with k = addr[1:0].
REQ-019 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-020 SHALL flag misaligned in IDLE when req=1 and any of: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; or we=1 with funct3 in {100,101}.
REQ-021 SHALL assert no memory write, no stall and rdata=0 for a misaligned request, and set err_sticky on that clock edge.
REQ-022 SHALL complete loads in zero cycles: rdata is combinational from mem_rd in the same cycle as req, with stall=0.
REQ-023 SHALL sign-extend B and H results and zero-extend BU and HU results; a halfword is taken from lane addr[1]*2.
REQ-024 SHALL drive rdata=0 whenever req=0, we=1, or the FSM is in WRITE.
REQ-025 SHALL perform an aligned SW in one cycle with mem_we=1, mem_wd=wdata and stall=0.
REQ-026 SHALL handle SB/SH in IDLE by holding mem_we=0, asserting stall=1, capturing {addr word, mem_rd with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]} into a merge register, and moving to WRITE.
REQ-027 SHALL, in WRITE, drive mem_a from the captured address, mem_wd from the merge register, mem_we=1 and stall=0, ignore all pipeline inputs, increment rmw_cnt, and return to IDLE.
REQ-028 SHALL saturate rmw_cnt at all-ones.
REQ-029 SHALL drive mem_a from addr in IDLE, and mem_wd=0 whenever mem_we=0.
REQ-030 SHALL allow a sub-word store to be presented back-to-back with another request after WRITE; IDLE evaluates the request presented in the cycle following WRITE.

Reset
REQ-031 SHALL, while rst=0, force FSM=IDLE, merge register=0, captured address=0, err_sticky=0 and rmw_cnt=0, with stall=0 and mem_we=0.
REQ-032 SHALL abandon an RMW in progress when rst is asserted in WRITE, with no memory write performed.
REQ-033 SHALL clear err_sticky only by reset.

Verification
REQ-034 SHALL cover: mem_rd=32'h80FF_7F01, LB addr=0x101 -> rdata=32'h0000_007F; LB addr=0x102 -> 32'hFFFF_FFFF; LHU addr=0x102 -> 32'h0000_80FF; stall=0 in all three.
REQ-035 SHALL cover: SB wdata=0xAB to addr=0x202 over old word 32'h1122_3344 -> cycle 0: stall=1, mem_we=0; cycle 1: mem_we=1, mem_wd=32'h11AB_3344, mem_a=0x200; then rmw_cnt=1.
REQ-036 SHALL cover: SW addr=0x301 -> misaligned=1, mem_we=0, stall=0, err_sticky=1 next edge; a following valid LW leaves err_sticky=1.
REQ-037 SHALL cover: SH to 0x402, rst pulled low in WRITE -> no mem_we pulse, FSM=IDLE, rmw_cnt=0, err_sticky=0.
REQ-038 SHALL cover: CNT_W=2 with 5 consecutive SB stores -> rmw_cnt reaches 3 and holds 3, each store taking exactly 2 cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store alignment unit for the MEM stage: extends loads and writes aligned words.
// Sub-word stores are merged with the old memory word over two cycles.
module mem_access_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      mem_rd,
  output logic [31:0]      mem_a,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             misaligned,
  output logic             err_sticky,
  output logic [CNT_W-1:0] rmw_cnt,
  output logic             fsm_state
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state;
  logic [31:0] cap_addr;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        is_idle, f_b, f_h, f_w, f_bu, f_hu;
  logic        illegal, mis_addr, go, load, store_word, sub_store;

  assign is_idle = (state == IDLE);
  assign f_b     = (funct3 == 3'b000);
  assign f_h     = (funct3 == 3'b001);
  assign f_w     = (funct3 == 3'b010);
  assign f_bu    = (funct3 == 3'b100);
  assign f_hu    = (funct3 == 3'b101);

  // Unsigned access types have no store form, so SBU/SHU are treated as illegal.
  assign illegal    = !(f_b || f_h || f_w || f_bu || f_hu) || (we && (f_bu || f_hu));
  assign mis_addr   = ((f_h || f_hu) && addr[0]) || (f_w && (addr[1:0] != 2'b00));
  assign misaligned = is_idle && req && (illegal || mis_addr);

  assign go         = rst && is_idle && req && !misaligned;
  assign load       = go && !we;
  assign store_word = go && we && f_w;
  assign sub_store  = go && we && (f_b || f_h);

  always_comb begin
    ld_byte = mem_rd[7:0];
    case (addr[1:0])
      2'd0: ld_byte = mem_rd[7:0];
      2'd1: ld_byte = mem_rd[15:8];
      2'd2: ld_byte = mem_rd[23:16];
      2'd3: ld_byte = mem_rd[31:24];
      default: ld_byte = mem_rd[7:0];
    endcase
  end

  assign ld_half = addr[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    rdata = '0;
    if (load) begin
      case (funct3)
        3'b000:  rdata = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  rdata = {{16{ld_half[15]}}, ld_half};
        3'b010:  rdata = mem_rd;
        3'b100:  rdata = {24'd0, ld_byte};
        3'b101:  rdata = {16'd0, ld_half};
        default: rdata = '0;
      endcase
    end
  end

  // Old word with the addressed lane(s) replaced; captured for the WRITE cycle.
  always_comb begin
    merged = mem_rd;
    if (f_h) begin
      if (addr[1]) merged[31:16] = wdata[15:0];
      else         merged[15:0]  = wdata[15:0];
    end else begin
      case (addr[1:0])
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        2'd3: merged[31:24] = wdata[7:0];
        default: merged = mem_rd;
      endcase
    end
  end

  assign mem_a     = is_idle ? {addr[31:2], 2'b00} : cap_addr;
  assign mem_we    = rst && (store_word || !is_idle);
  assign mem_wd    = !mem_we ? 32'd0 : (is_idle ? wdata : merge_q);
  assign stall     = sub_store;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cap_addr   <= '0;
      merge_q    <= '0;
      err_sticky <= 1'b0;
      rmw_cnt    <= '0;
    end else begin
      if (misaligned) err_sticky <= 1'b1;
      case (state)
        IDLE: begin
          if (sub_store) begin
            cap_addr <= {addr[31:2], 2'b00};
            merge_q  <= merged;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (rmw_cnt != {CNT_W{1'b1}}) rmw_cnt <= rmw_cnt + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vectors, a per-cycle reference model and
// literal spot checks; a second instance with a 2-bit counter shares the stimulus.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rd;

  logic [31:0] d1_mem_a, d1_mem_wd, d1_rdata;
  logic        d1_mem_we, d1_stall, d1_mis, d1_err, d1_state;
  logic [15:0] d1_cnt;
  logic [31:0] d2_mem_a, d2_mem_wd, d2_rdata;
  logic        d2_mem_we, d2_stall, d2_mis, d2_err, d2_state;
  logic [1:0]  d2_cnt;

  int cmp_count  = 0;
  int fail_count = 0;

  // Pending merged writes: {word address, data}
  logic [63:0] exp_q[$];
  logic        m_err;
  int          m_cnt;
  logic        n_push, n_pop, n_err, n_inc;
  logic [63:0] n_item;

  mem_access_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .mem_rd(mem_rd), .mem_a(d1_mem_a), .mem_we(d1_mem_we),
    .mem_wd(d1_mem_wd), .rdata(d1_rdata), .stall(d1_stall), .misaligned(d1_mis),
    .err_sticky(d1_err), .rmw_cnt(d1_cnt), .fsm_state(d1_state)
  );

  mem_access_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .mem_rd(mem_rd), .mem_a(d2_mem_a), .mem_we(d2_mem_we),
    .mem_wd(d2_mem_wd), .rdata(d2_rdata), .stall(d2_stall), .misaligned(d2_mis),
    .err_sticky(d2_err), .rmw_cnt(d2_cnt), .fsm_state(d2_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: present one request after the edge, return at the following falling edge
  task automatic step(input logic r, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
    @(posedge clk);
    #1;
    req = r; we = w; funct3 = f; addr = a; wdata = d; mem_rd = rd;
    @(negedge clk);
  endtask

  // Model state update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_err = 1'b0; m_cnt = 0;
      n_push = 1'b0; n_pop = 1'b0; n_err = 1'b0; n_inc = 1'b0;
    end else begin
      if (n_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (n_push) exp_q.push_back(n_item);
      if (n_err) m_err = 1'b1;
      if (n_inc) m_cnt++;
      n_push = 1'b0; n_pop = 1'b0; n_err = 1'b0; n_inc = 1'b0;
    end
  end

  // Compare process: expected outputs from access-size rules, checked every cycle
  always @(negedge clk) begin
    logic [31:0] e_a, e_wd, e_rd, val, merged, mask;
    logic        e_we, e_st, e_mis, e_state, sgn, legal;
    int          sz, off, c1, c2;
    if (rst_n === 1'b0) begin
      check("rst_stall", d1_stall, 0);
      check("rst_mem_we", d1_mem_we, 0);
      check("rst_err", d1_err, 0);
      check("rst_cnt", d1_cnt, 0);
      check("rst_state", d1_state, 0);
      check("rst_cnt2", d2_cnt, 0);
    end else begin
      e_we = 0; e_st = 0; e_mis = 0; e_rd = 0; e_wd = 0;
      off = int'(addr % 32'd4);
      e_a = addr - 32'(off);
      e_state = (exp_q.size() != 0);
      if (e_state) begin
        e_a = exp_q[0][63:32]; e_wd = exp_q[0][31:0]; e_we = 1;
        n_pop = 1; n_inc = 1;
      end else if (req) begin
        legal = 1; sgn = 0; sz = 1;
        case (funct3)
          3'd0: begin sz = 1; sgn = 1; end
          3'd1: begin sz = 2; sgn = 1; end
          3'd2: sz = 4;
          3'd4: sz = 1;
          3'd5: sz = 2;
          default: legal = 0;
        endcase
        if (we && (funct3 == 3'd4 || funct3 == 3'd5)) legal = 0;
        if (!legal || (off % sz) != 0) begin
          e_mis = 1; n_err = 1;
        end else if (!we) begin
          val = mem_rd >> (8 * off);
          if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            val = val & mask;
            if (sgn && val[8 * sz - 1]) val = val | ~mask;
          end
          e_rd = val;
        end else if (sz == 4) begin
          e_we = 1; e_wd = wdata;
        end else begin
          e_st = 1;
          merged = mem_rd;
          for (int i = 0; i < sz; i++) merged[8 * (off + i) +: 8] = wdata[8 * i +: 8];
          n_push = 1; n_item = {e_a, merged};
        end
      end
      c1 = (m_cnt > 65535) ? 65535 : m_cnt;
      c2 = (m_cnt > 3) ? 3 : m_cnt;
      check("mem_a", d1_mem_a, e_a);
      check("mem_we", d1_mem_we, e_we);
      check("mem_wd", d1_mem_wd, e_wd);
      check("rdata", d1_rdata, e_rd);
      check("stall", d1_stall, e_st);
      check("misaligned", d1_mis, e_mis);
      check("err_sticky", d1_err, m_err);
      check("rmw_cnt", d1_cnt, 32'(c1));
      check("fsm_state", d1_state, e_state);
      check("rmw_cnt_w2", d2_cnt, 32'(c2));
      check("stall_w2", d2_stall, e_st);
      check("mem_we_w2", d2_mem_we, e_we);
    end
  end

  initial begin
    // Reset with a valid SW presented: no write may escape
    rst_n = 1'b0;
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h1234_5678; mem_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_rst_mem_we", d1_mem_we, 0);
    check("lit_rst_stall", d1_stall, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = 1'b0; we = 1'b0;

    // Byte/halfword loads from one word
    step(1, 0, 3'b000, 32'h101, 0, 32'h80FF_7F01);
    check("lit_lb_101", d1_rdata, 32'h0000_007F);
    check("lit_lb_101_stall", d1_stall, 0);
    step(1, 0, 3'b000, 32'h102, 0, 32'h80FF_7F01);
    check("lit_lb_102", d1_rdata, 32'hFFFF_FFFF);
    check("lit_lb_102_stall", d1_stall, 0);
    step(1, 0, 3'b101, 32'h102, 0, 32'h80FF_7F01);
    check("lit_lhu_102", d1_rdata, 32'h0000_80FF);
    check("lit_lhu_102_stall", d1_stall, 0);

    // Aligned word store
    step(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0);
    check("lit_sw_we", d1_mem_we, 1);
    check("lit_sw_wd", d1_mem_wd, 32'hDEAD_BEEF);
    check("lit_sw_stall", d1_stall, 0);

    // SB into lane 2; during WRITE present a misaligned LW that must be ignored
    step(1, 1, 3'b000, 32'h202, 32'h0000_00AB, 32'h1122_3344);
    check("lit_sb_c0_stall", d1_stall, 1);
    check("lit_sb_c0_we", d1_mem_we, 0);
    step(1, 0, 3'b010, 32'h301, 32'hFFFF_FFFF, 32'h0);
    check("lit_sb_c1_we", d1_mem_we, 1);
    check("lit_sb_c1_wd", d1_mem_wd, 32'h11AB_3344);
    check("lit_sb_c1_a", d1_mem_a, 32'h200);
    check("lit_sb_c1_mis", d1_mis, 0);
    step(0, 0, 3'b000, 32'h0, 0, 32'h0);
    check("lit_sb_cnt", d1_cnt, 1);
    check("lit_sb_err", d1_err, 0);

    // SH upper half then a load right after WRITE
    step(1, 1, 3'b001, 32'h406, 32'h1234_BEEF, 32'hAABB_CCDD);
    step(0, 1, 3'b000, 32'h0, 0, 32'h0);
    check("lit_sh_wd", d1_mem_wd, 32'hBEEF_CCDD);
    check("lit_sh_a", d1_mem_a, 32'h404);
    step(1, 0, 3'b001, 32'h402, 0, 32'h8001_0000);
    check("lit_lh_b2b", d1_rdata, 32'hFFFF_8001);

    // More loads and sub-word stores on other lanes
    step(1, 0, 3'b010, 32'h20, 0, 32'hCAFE_F00D);
    step(1, 0, 3'b100, 32'h23, 0, 32'h9A00_0000);
    check("lit_lbu_23", d1_rdata, 32'h0000_009A);
    step(1, 0, 3'b001, 32'h20, 0, 32'h0000_8000);
    step(1, 0, 3'b101, 32'h20, 0, 32'h0000_8000);
    step(1, 0, 3'b000, 32'h21, 0, 32'h0000_8000);
    step(1, 1, 3'b000, 32'h33, 32'h0000_0055, 32'h0102_0304);
    step(0, 0, 3'b000, 32'h0, 0, 32'h0);
    check("lit_sb_l3_wd", d1_mem_wd, 32'h5502_0304);
    step(1, 1, 3'b001, 32'h40, 32'hFFFF_1357, 32'hA5A5_A5A5);
    step(1, 1, 3'b010, 32'h44, 32'h1, 32'h0);
    step(0, 1, 3'b010, 32'h44, 32'h1, 32'h0);

    // Misaligned SW latches err_sticky; a valid LW does not clear it
    step(1, 1, 3'b010, 32'h301, 32'h7777_7777, 32'h0);
    check("lit_sw301_mis", d1_mis, 1);
    check("lit_sw301_we", d1_mem_we, 0);
    check("lit_sw301_stall", d1_stall, 0);
    check("lit_sw301_err_pre", d1_err, 0);
    step(1, 0, 3'b010, 32'h300, 0, 32'h0000_0055);
    check("lit_err_set", d1_err, 1);
    check("lit_lw300", d1_rdata, 32'h55);
    step(0, 0, 3'b000, 32'h0, 0, 32'h0);
    check("lit_err_hold", d1_err, 1);

    // Illegal encodings and odd halfwords
    step(1, 0, 3'b011, 32'h50, 0, 32'hFFFF_FFFF);
    step(1, 1, 3'b100, 32'h50, 32'h11, 32'hFFFF_FFFF);
    step(1, 1, 3'b101, 32'h52, 32'h11, 32'hFFFF_FFFF);
    step(1, 0, 3'b001, 32'h101, 0, 32'hFFFF_FFFF);
    step(1, 0, 3'b101, 32'h103, 0, 32'hFFFF_FFFF);
    step(1, 0, 3'b110, 32'h50, 0, 32'hFFFF_FFFF);
    step(1, 1, 3'b111, 32'h50, 0, 32'hFFFF_FFFF);
    step(0, 0, 3'b010, 32'h50, 0, 32'hFFFF_FFFF);

    // Reset asserted during WRITE abandons the RMW
    step(1, 1, 3'b001, 32'h402, 32'h0000_7777, 32'h0102_0304);
    check("lit_rstw_stall", d1_stall, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("lit_rstw_we", d1_mem_we, 0);
    check("lit_rstw_state", d1_state, 0);
    check("lit_rstw_cnt", d1_cnt, 0);
    check("lit_rstw_err", d1_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Five back-to-back SB stores: the 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3'b000, 32'h500 + 32'(i), 32'(8'hC0 + i), 32'h0);
      check("lit_sat_c0_stall", d2_stall, 1);
      step(0, 0, 3'b000, 32'h0, 0, 32'h0);
      check("lit_sat_c1_we", d2_mem_we, 1);
    end
    step(0, 0, 3'b000, 32'h0, 0, 32'h0);
    check("lit_sat_cnt2", d2_cnt, 3);
    check("lit_sat_cnt16", d1_cnt, 5);
    step(0, 0, 3'b000, 32'h0, 0, 32'h0);
    check("lit_sat_hold", d2_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
